// File: rtl/fmul_share_arb.sv
// Two-requester front end for one shared 5-stage pipelined FP multiplier.
// Requests are granted round-robin on the input side. A tag/valid shadow pipe
// follows each operation through the multiplier and steers its result back to
// the requester that issued it. A result the head's owner cannot take freezes
// the whole shared pipe.
module fmul_share_arb #(
  parameter int unsigned LAT   = 5,
  parameter int unsigned CNT_W = 3
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_rm,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_rm,
  output logic             res0_valid,
  input  logic             res0_ready,
  output logic             res1_valid,
  input  logic             res1_ready,
  output logic [31:0]      res_x,
  output logic             mul_a_sign,
  output logic             mul_b_sign,
  output logic [7:0]       mul_a_exp,
  output logic [7:0]       mul_b_exp,
  output logic [22:0]      mul_a_man,
  output logic [22:0]      mul_b_man,
  output logic [2:0]       mul_rm,
  output logic             mul_astall,
  input  logic [31:0]      mul_x,
  output logic [CNT_W-1:0] inflight,
  output logic             busy
);

  logic [LAT:1]     vld_q, vld_d;
  logic [LAT:1]     tag_q, tag_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        head_rdy;
  logic        stall;
  logic        any_req;
  logic        win_id;
  logic        accept;
  logic        complete;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [2:0]  sel_rm;

  // Head-of-pipe stall and round-robin grant.
  always_comb begin
    head_rdy = tag_q[LAT] ? res1_ready : res0_ready;
    stall    = vld_q[LAT] & ~head_rdy;
    any_req  = req0_valid | req1_valid;
    // Contended grant follows the pointer; a lone requester always wins.
    win_id   = req0_valid ? (req1_valid & ptr_q) : 1'b1;
    accept   = any_req & ~stall;
    complete = vld_q[LAT] & ~stall;
  end

  // Winner's operands go straight to the multiplier; zeros when idle.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_rm = '0;
    if (any_req) begin
      sel_a  = win_id ? req1_a  : req0_a;
      sel_b  = win_id ? req1_b  : req0_b;
      sel_rm = win_id ? req1_rm : req0_rm;
    end
  end

  assign req0_ready = accept & ~win_id;
  assign req1_ready = accept &  win_id;
  assign mul_a_sign = sel_a[31];
  assign mul_a_exp  = sel_a[30:23];
  assign mul_a_man  = sel_a[22:0];
  assign mul_b_sign = sel_b[31];
  assign mul_b_exp  = sel_b[30:23];
  assign mul_b_man  = sel_b[22:0];
  assign mul_rm     = sel_rm;
  assign mul_astall = stall;
  assign res0_valid = vld_q[LAT] & ~tag_q[LAT];
  assign res1_valid = vld_q[LAT] &  tag_q[LAT];
  assign res_x      = mul_x;
  assign inflight   = cnt_q;
  assign busy       = |cnt_q;

  // Next state: shadow pipe advances in lockstep with the multiplier enable.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (!stall) begin
      vld_d[1] = accept;
      tag_d[1] = win_id;
      for (int unsigned i = 2; i <= LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end
    if (accept) begin
      ptr_d = ~win_id;
    end
    if (accept && !complete) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!accept && complete) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // State registers with synchronous reset; clearing vld drops in-flight work.
  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_q <= '0;
      tag_q <= '0;
      ptr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fmul_share_arb.sv
// Bench for fmul_share_arb: drives a stand-in 5-stage enable-stalled
// multiplier, checks every cycle against a queue-based reference model, and
// runs directed scenarios with hand-computed expectations followed by a
// randomized phase.
module tb_fmul_share_arb;
  localparam int LAT   = 5;
  localparam int CNT_W = 3;

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]       req0_rm = '0, req1_rm = '0;
  logic             res0_valid, res1_valid;
  logic             res0_ready = 1'b1, res1_ready = 1'b1;
  logic [31:0]      res_x;
  logic             mul_a_sign, mul_b_sign;
  logic [7:0]       mul_a_exp, mul_b_exp;
  logic [22:0]      mul_a_man, mul_b_man;
  logic [2:0]       mul_rm;
  logic             mul_astall;
  logic [31:0]      mul_x;
  logic [CNT_W-1:0] inflight;
  logic             busy;

  int checks = 0;
  int failures = 0;

  fmul_share_arb #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .areset(areset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_rm(req0_rm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_rm(req1_rm),
    .res0_valid(res0_valid), .res0_ready(res0_ready), .res1_valid(res1_valid), .res1_ready(res1_ready),
    .res_x(res_x),
    .mul_a_sign(mul_a_sign), .mul_b_sign(mul_b_sign), .mul_a_exp(mul_a_exp), .mul_b_exp(mul_b_exp),
    .mul_a_man(mul_a_man), .mul_b_man(mul_b_man), .mul_rm(mul_rm), .mul_astall(mul_astall),
    .mul_x(mul_x), .inflight(inflight), .busy(busy)
  );

  always #5 aclk = ~aclk;

  // Truncating single-precision multiply for normal operands.
  function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
    logic [47:0] p;
    int          e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) return {a[31] ^ b[31], 8'(e + 1), p[46:24]};
    return {a[31] ^ b[31], 8'(e), p[45:23]};
  endfunction

  function automatic logic [31:0] rnd_op();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Stand-in multiplier: 5 enable-gated stages, never reset.
  logic [31:0] mpipe [1:LAT];
  always @(posedge aclk) begin
    if (!mul_astall) begin
      mpipe[1] <= fmul({mul_a_sign, mul_a_exp, mul_a_man}, {mul_b_sign, mul_b_exp, mul_b_man});
      for (int i = LAT; i > 1; i--) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_x = mpipe[LAT];

  // Reference model: ordered list of in-flight ops, each aging one step per
  // non-stalled cycle; an op whose age reaches LAT is the presented result.
  typedef struct {
    int          req;
    logic [31:0] val;
    int          age;
  } ent_t;
  ent_t q[$];
  int   ptr_m = 0;
  bit   armed = 0;

  always @(negedge aclk) begin : model
    int          win;
    bit          head, stall_e;
    logic [31:0] ea, eb;
    logic [2:0]  erm;
    head    = (q.size() > 0) && (q[0].age == LAT);
    stall_e = head && !(q[0].req == 0 ? res0_ready : res1_ready);
    if (req0_valid && req1_valid) win = ptr_m;
    else if (req0_valid)          win = 0;
    else if (req1_valid)          win = 1;
    else                          win = -1;
    ea  = (win == 0) ? req0_a  : (win == 1) ? req1_a  : 32'd0;
    eb  = (win == 0) ? req0_b  : (win == 1) ? req1_b  : 32'd0;
    erm = (win == 0) ? req0_rm : (win == 1) ? req1_rm : 3'd0;
    if (armed) begin
      chk("m_stall",      32'(mul_astall), 32'(stall_e));
      chk("m_req0_ready", 32'(req0_ready), 32'(win == 0 && !stall_e));
      chk("m_req1_ready", 32'(req1_ready), 32'(win == 1 && !stall_e));
      chk("m_res0_valid", 32'(res0_valid), 32'(head && q[0].req == 0));
      chk("m_res1_valid", 32'(res1_valid), 32'(head && q[0].req == 1));
      if (head) chk("m_res_x", res_x, q[0].val);
      chk("m_inflight",   32'(inflight), 32'(q.size()));
      chk("m_busy",       32'(busy), 32'(q.size() != 0));
      chk("m_mul_a", {mul_a_sign, mul_a_exp, mul_a_man}, ea);
      chk("m_mul_b", {mul_b_sign, mul_b_exp, mul_b_man}, eb);
      chk("m_mul_rm", 32'(mul_rm), 32'(erm));
    end
    if (areset) begin
      q.delete();
      ptr_m = 0;
      armed = 1;
    end else if (!stall_e) begin
      if (head) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (win >= 0) begin
        q.push_back('{win, fmul(ea, eb), 1});
        ptr_m = 1 - win;
      end
    end
  end

  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  task automatic smp();
    @(negedge aclk);
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res0_ready = 1'b1;
    res1_ready = 1'b1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    idle();
    nxt();
    nxt();
    areset = 1'b0;
  endtask

  initial begin : stim
    int delivered;
    do_reset();
    smp();
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_res0_valid", 32'(res0_valid), 32'd0);
    chk("rst_res1_valid", 32'(res1_valid), 32'd0);
    chk("rst_busy",       32'(busy), 32'd0);
    chk("rst_stall",      32'(mul_astall), 32'd0);
    chk("rst_inflight",   32'(inflight), 32'd0);
    nxt();

    // Single op: 1.5 * 2.0 = 3.0, five cycles later.
    req0_valid = 1'b1; req0_a = 32'h3FC00000; req0_b = 32'h40000000; req0_rm = 3'd0;
    smp();
    chk("single_ready", 32'(req0_ready), 32'd1);
    nxt();
    req0_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      smp();
      if (k == 1) chk("single_inflight1", 32'(inflight), 32'd1);
      if (k < 5) chk("single_early", 32'(res0_valid), 32'd0);
      if (k == 5) begin
        chk("single_res_valid", 32'(res0_valid), 32'd1);
        chk("single_res_x", res_x, 32'h40400000);
      end
      nxt();
    end
    smp();
    chk("single_inflight0", 32'(inflight), 32'd0);
    nxt();

    // Contention: grants alternate starting with requester 0.
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      req0_valid = (c < 6); req1_valid = (c < 6);
      req0_a = rnd_op(); req0_b = rnd_op(); req0_rm = 3'($urandom);
      req1_a = rnd_op(); req1_b = rnd_op(); req1_rm = 3'($urandom);
      smp();
      if (c < 6) begin
        chk("cont_grant0", 32'(req0_ready), 32'(c % 2 == 0));
        chk("cont_grant1", 32'(req1_ready), 32'(c % 2 == 1));
      end
      if (c >= 5) begin
        chk("cont_res0", 32'(res0_valid), 32'(c % 2 == 1));
        chk("cont_res1", 32'(res1_valid), 32'(c % 2 == 0));
      end
      chk("cont_stall", 32'(mul_astall), 32'd0);
      nxt();
    end

    // Back-pressure: 5 ops, head blocked for 3 cycles.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req0_valid = 1'b1; req0_a = rnd_op(); req0_b = rnd_op(); req0_rm = 3'($urandom);
      res0_ready = !(c >= 5);
      smp();
      if (c < 5) chk("bp_accept", 32'(req0_ready), 32'd1);
      else begin
        chk("bp_stall", 32'(mul_astall), 32'd1);
        chk("bp_ready_low", 32'(req0_ready), 32'd0);
      end
      if (c == 5) chk("bp_inflight_peak", 32'(inflight), 32'd5);
      nxt();
    end
    idle();
    delivered = 0;
    for (int c = 8; c < 15; c++) begin
      smp();
      if (c == 8) chk("bp_release", 32'(mul_astall), 32'd0);
      if (res0_valid && res0_ready) delivered++;
      nxt();
    end
    chk("bp_delivered", 32'(delivered), 32'd5);

    // Bubble at the head never stalls.
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      req0_valid = (c == 0 || c == 2); req0_a = rnd_op(); req0_b = rnd_op();
      res0_ready = !(c == 6 || c == 7);
      smp();
      if (c == 6) chk("bub_no_stall", 32'(mul_astall), 32'd0);
      if (c == 7) chk("bub_stall", 32'(mul_astall), 32'd1);
      if (c == 8) begin
        chk("bub_release", 32'(mul_astall), 32'd0);
        chk("bub_res", 32'(res0_valid), 32'd1);
      end
      nxt();
    end

    // Reset mid-flight: results discarded, pointer back to requester 0.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = rnd_op(); req0_b = rnd_op(); req1_a = rnd_op(); req1_b = rnd_op();
      nxt();
    end
    idle();
    areset = 1'b1;
    nxt();
    areset = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      req0_valid = (c == 4); req1_valid = (c == 4);
      smp();
      if (c == 4) begin
        chk("rmid_inflight", 32'(inflight), 32'd0);
        chk("rmid_ptr0", 32'(req0_ready), 32'd1);
      end
      chk("rmid_res0", 32'(res0_valid), 32'd0);
      chk("rmid_res1", 32'(res1_valid), 32'd0);
      nxt();
    end
    idle();

    // Pointer holds through a stall, then moves after the req1 accept.
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      req0_valid = (c == 0 || c == 8); req0_a = rnd_op(); req0_b = rnd_op();
      req1_valid = (c >= 5);           req1_a = rnd_op(); req1_b = rnd_op();
      res0_ready = !(c == 5 || c == 6);
      smp();
      if (c == 5 || c == 6) chk("ph_blocked", 32'(req1_ready), 32'd0);
      if (c == 7) chk("ph_req1_acc", 32'(req1_ready), 32'd1);
      if (c == 8) begin
        chk("ph_ptr_req0", 32'(req0_ready), 32'd1);
        chk("ph_ptr_req1", 32'(req1_ready), 32'd0);
      end
      nxt();
    end
    idle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      areset     = ($urandom_range(0, 299) == 0);
      req0_valid = 1'($urandom_range(0, 2) != 0);
      req1_valid = 1'($urandom_range(0, 2) != 0);
      req0_a = rnd_op(); req0_b = rnd_op(); req0_rm = 3'($urandom);
      req1_a = rnd_op(); req1_b = rnd_op(); req1_rm = 3'($urandom);
      res0_ready = 1'($urandom_range(0, 4) != 0);
      res1_ready = 1'($urandom_range(0, 4) != 0);
      nxt();
    end
    areset = 1'b0;
    idle();
    for (int c = 0; c < 10; c++) nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
